frv_asi_arb: RTL and testbench
==============================

Name: frv_asi_arb

Overview:
- Two-requester arbiter and sequencer in front of the single shared algorithm-specific-instruction (ASI) unit (AES sub/mix, SHA2, SHA3).
- Requester 0 is the core execute stage; requester 1 is the crypto co-issue port (e.g. a second hart or an offload sequencer).
- Grants the ASI unit to one requester at a time and holds the grant across multi-cycle AES operations.
- Flushes AES submodule state when AES ownership changes hands, so state never leaks between requesters.

Parameters:
- XLEN, 32, datapath width; XL = XLEN-1.
- OP, 4, MSB index of the micro-op field; uop class is uop[OP:OP-1].
- AES_CLASS, 2'b01, uop class value that identifies AES operations.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous reset, active-high.
- req0_valid / req1_valid  in  1  request pending; held until the matching ready.
- req0_uop / req1_uop  in  OP+1  operation.
- req0_rs1, req0_rs2 / req1_rs1, req1_rs2  in  XLEN  operands.
- req0_shamt / req1_shamt  in  2  SHA3 shift amount.
- req0_ready / req1_ready  out  1  operation complete this cycle.
- req0_result / req1_result  out  XLEN  result; valid only while ready=1, else 0.
- asi_valid  out  1  drive to ASI unit.
- asi_uop, asi_rs1, asi_rs2, asi_shamt  out  -  muxed operands from the owning requester; 0 when idle.
- asi_flush_aessub, asi_flush_aesmix  out  1  one-cycle flush pulses.
- asi_flush_data  out  32  always 0.
- asi_ready  in  1  ASI unit completion.
- asi_result  in  XLEN  ASI unit result.

Behaviour:
- States: IDLE, FLUSH, BUSY.
- Registers:
  - owner (1 bit).
  - aes_owner (2 bits: 0, 1, or NONE).
  - prio (1 bit, the requester favoured next).
- Reset: state=IDLE, owner=0, aes_owner=NONE, prio=0. All outputs 0.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant prio.
  - On grant, owner is registered. If the uop is AES and aes_owner != the new owner, go to FLUSH; otherwise go to BUSY.
  - asi_valid=0 while in IDLE, so a request waits at least 1 cycle before issue.
- FLUSH (exactly 1 cycle):
  - asi_flush_aessub=asi_flush_aesmix=1 and asi_valid=0.
  - aes_owner<=owner; next state BUSY.
- BUSY:
  - asi_valid=1 with the owner's operands.
  - req<owner>_ready = asi_ready and req<owner>_result = asi_result, combinational from the ASI unit.
  - Non-owner ready=0 and result=0.
  - On asi_ready: prio<=~owner, next state IDLE.
  - A non-AES op completes in 1 cycle, giving issue-to-ready latency of 2 cycles from request (IDLE + BUSY).
- Abort: if the owner drops valid in BUSY or FLUSH before ready:
  - Return to IDLE with no ready pulse.
  - Pulse both flushes next cycle, one cycle in IDLE with flushes high.
  - Set aes_owner=NONE.
- A non-AES op never changes aes_owner and never triggers a flush.
- Simultaneous asi_ready and an owner valid drop in the same cycle: treated as completion; ready is asserted.
- Reset mid-operation: immediately IDLE, all outputs 0, aes_owner=NONE, no ready pulse.
- The non-owner's request is never dropped. It is granted next after the owner completes (round-robin).

Optional Feature:
- Macro FRV_ASI_ARB_RR_EN.
- Defined: round-robin; prio toggles to the non-owner on every completion, as above.
- Undefined: fixed priority; requester 0 always wins simultaneous requests and the prio register is removed.
  - Requester 1 can starve under continuous requester-0 traffic; this is acceptable for single-hart builds.

Test Plan:
- Single SHA2 request:
  - Stimulus: req0_valid=1 with a SHA2 uop, rs1=32'h6a09e667, asi_ready returning 1 in the first BUSY cycle.
  - Response: asi_valid high in cycle 1; req0_ready=1 with req0_result=asi_result in cycle 1; back to IDLE in cycle 2; no flush pulse.
- Contention with RR_EN defined:
  - Stimulus: req0 and req1 both valid with SHA3 ops from reset.
  - Response: req0 served first (prio=0), then req1; grant order 0,1,0,1 over 4 back-to-back requests.
- AES ownership change:
  - Stimulus: req0 AES op completes, then req1 issues an AES op.
  - Response: exactly one cycle with both flushes=1 and asi_valid=0 before req1's BUSY; a second req1 AES op issues with no flush.
- Multi-cycle AES:
  - Stimulus: asi_ready held low for 3 BUSY cycles while req1 is valid.
  - Response: grant stays with req0, req1_ready=0 throughout, req1 is granted right after req0_ready.
- Abort:
  - Stimulus: req0 drops valid in the second BUSY cycle.
  - Response: no req0_ready; next cycle IDLE with flushes=1; aes_owner=NONE.
- Reset and fixed priority:
  - Stimulus: g_reset=1 during BUSY.
  - Response: all outputs 0 the next cycle.
  - With RR_EN undefined and simultaneous requests, req0 wins every time.

Source files
------------

// File: rtl/frv_asi_arb.sv
// rtl/frv_asi_arb.sv - two-requester arbiter/sequencer in front of the shared ASI unit
// Define FRV_ASI_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req0 wins).
module frv_asi_arb #(
  parameter int         XLEN      = 32,
  parameter int         OP        = 4,
  parameter logic [1:0] AES_CLASS = 2'b01
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            req0_valid,
  input  logic [OP:0]     req0_uop,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [1:0]      req0_shamt,
  output logic            req0_ready,
  output logic [XLEN-1:0] req0_result,
  input  logic            req1_valid,
  input  logic [OP:0]     req1_uop,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [1:0]      req1_shamt,
  output logic            req1_ready,
  output logic [XLEN-1:0] req1_result,
  output logic            asi_valid,
  output logic [OP:0]     asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  output logic            asi_flush_aessub,
  output logic            asi_flush_aesmix,
  output logic [31:0]     asi_flush_data,
  input  logic            asi_ready,
  input  logic [XLEN-1:0] asi_result
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_BUSY} state_t;
  localparam logic [1:0] AES_NONE = 2'b10;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  aes_owner_q, aes_owner_d;
  logic        abort_flush_q, abort_flush_d;
  logic        gnt, gnt_aes, own_valid;
  logic [OP:0] gnt_uop;

`ifdef FRV_ASI_ARB_RR_EN
  logic prio_q, prio_d;
  assign gnt = req1_valid & (~req0_valid | prio_q);
`else
  assign gnt = req1_valid & ~req0_valid;
`endif

  assign gnt_uop        = gnt ? req1_uop : req0_uop;
  assign gnt_aes        = (gnt_uop[OP:OP-1] == AES_CLASS);
  assign own_valid      = owner_q ? req1_valid : req0_valid;
  assign asi_flush_data = 32'd0;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    aes_owner_d      = aes_owner_q;
    abort_flush_d    = 1'b0;
`ifdef FRV_ASI_ARB_RR_EN
    prio_d           = prio_q;
`endif
    asi_valid        = 1'b0;
    asi_uop          = '0;
    asi_rs1          = '0;
    asi_rs2          = '0;
    asi_shamt        = '0;
    asi_flush_aessub = 1'b0;
    asi_flush_aesmix = 1'b0;
    req0_ready       = 1'b0;
    req0_result      = '0;
    req1_ready       = 1'b0;
    req1_result      = '0;
    case (state_q)
      S_IDLE: begin
        // An aborted operation leaves AES state dirty; scrub it on the way out.
        asi_flush_aessub = abort_flush_q;
        asi_flush_aesmix = abort_flush_q;
        if (req0_valid | req1_valid) begin
          owner_d = gnt;
          state_d = (gnt_aes && (aes_owner_q != {1'b0, gnt})) ? S_FLUSH : S_BUSY;
        end
      end
      S_FLUSH: begin
        asi_flush_aessub = 1'b1;
        asi_flush_aesmix = 1'b1;
        if (!own_valid) begin
          state_d       = S_IDLE;
          abort_flush_d = 1'b1;
          aes_owner_d   = AES_NONE;
        end else begin
          state_d     = S_BUSY;
          aes_owner_d = {1'b0, owner_q};
        end
      end
      S_BUSY: begin
        asi_valid = 1'b1;
        asi_uop   = owner_q ? req1_uop   : req0_uop;
        asi_rs1   = owner_q ? req1_rs1   : req0_rs1;
        asi_rs2   = owner_q ? req1_rs2   : req0_rs2;
        asi_shamt = owner_q ? req1_shamt : req0_shamt;
        if (owner_q) begin
          req1_ready  = asi_ready;
          req1_result = asi_ready ? asi_result : '0;
        end else begin
          req0_ready  = asi_ready;
          req0_result = asi_ready ? asi_result : '0;
        end
        // Completion wins over a same-cycle valid drop.
        if (asi_ready) begin
          state_d = S_IDLE;
`ifdef FRV_ASI_ARB_RR_EN
          prio_d  = ~owner_q;
`endif
        end else if (!own_valid) begin
          state_d       = S_IDLE;
          abort_flush_d = 1'b1;
          aes_owner_d   = AES_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      aes_owner_q   <= AES_NONE;
      abort_flush_q <= 1'b0;
`ifdef FRV_ASI_ARB_RR_EN
      prio_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      aes_owner_q   <= aes_owner_d;
      abort_flush_q <= abort_flush_d;
`ifdef FRV_ASI_ARB_RR_EN
      prio_q        <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_frv_asi_arb.sv
// tb/tb_frv_asi_arb.sv - scoreboard bench for frv_asi_arb
// Expected grant order adapts to FRV_ASI_ARB_RR_EN.
module tb_frv_asi_arb;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_uop = '0, req1_uop = '0;
  logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
  logic [1:0]  req0_shamt = '0, req1_shamt = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_result, req1_result;
  logic        asi_valid;
  logic [4:0]  asi_uop;
  logic [31:0] asi_rs1, asi_rs2;
  logic [1:0]  asi_shamt;
  logic        asi_flush_aessub, asi_flush_aesmix;
  logic [31:0] asi_flush_data;
  logic        asi_ready;
  logic [31:0] asi_result;

  frv_asi_arb #(.XLEN(32), .OP(4), .AES_CLASS(2'b01)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req0_valid(req0_valid), .req0_uop(req0_uop), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_shamt(req0_shamt), .req0_ready(req0_ready), .req0_result(req0_result),
    .req1_valid(req1_valid), .req1_uop(req1_uop), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_shamt(req1_shamt), .req1_ready(req1_ready), .req1_result(req1_result),
    .asi_valid(asi_valid), .asi_uop(asi_uop), .asi_rs1(asi_rs1), .asi_rs2(asi_rs2),
    .asi_shamt(asi_shamt), .asi_flush_aessub(asi_flush_aessub), .asi_flush_aesmix(asi_flush_aesmix),
    .asi_flush_data(asi_flush_data), .asi_ready(asi_ready), .asi_result(asi_result)
  );

  always #5 g_clk = ~g_clk;

  // ASI unit model: latency = rs2[1:0] extra BUSY cycles; result mixes every operand field.
  int busy_cnt = 0;
  always @(posedge g_clk) begin
    if (g_reset || !asi_valid || asi_ready) busy_cnt <= 0;
    else busy_cnt <= busy_cnt + 1;
  end
  assign asi_ready  = asi_valid && (busy_cnt == int'(asi_rs2[1:0]));
  assign asi_result = asi_rs1 ^ {asi_rs2[15:0], asi_rs2[31:16]} ^ {25'b0, asi_shamt, asi_uop};

  typedef struct {
    logic [4:0]  uop;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  shamt;
  } op_t;

  typedef struct {
    bit          is_flush;
    bit          who;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  op_t  pend0[$];
  op_t  pend1[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  localparam logic [4:0] U_AES  = 5'b01000;
  localparam logic [4:0] U_SHA2 = 5'b10000;
  localparam logic [4:0] U_SHA3 = 5'b11000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(op_t o);
    return o.rs1 ^ {o.rs2[15:0], o.rs2[31:16]} ^ {25'b0, o.shamt, o.uop};
  endfunction

  function automatic op_t mk(logic [4:0] u, logic [31:0] a, logic [31:0] b, logic [1:0] s);
    op_t o;
    o.uop = u; o.rs1 = a; o.rs2 = b; o.shamt = s;
    return o;
  endfunction

  task automatic exp_ready(bit w, op_t o);
    exp_t e;
    e.is_flush = 1'b0; e.who = w; e.res = model(o);
    sb.push_back(e);
  endtask

  task automatic exp_flush();
    exp_t e;
    e.is_flush = 1'b1; e.who = 1'b0; e.res = '0;
    sb.push_back(e);
  endtask

  // Monitor: every visible ready or flush pulse consumes one scoreboard entry.
  always @(negedge g_clk) begin
    if (!g_reset) begin
      if (req0_ready || req1_ready || asi_flush_aessub || asi_flush_aesmix) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 32'({req1_ready, req0_ready, asi_flush_aesmix, asi_flush_aessub}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_flush) begin
            chk("flush_aessub", 32'(asi_flush_aessub), 32'd1);
            chk("flush_aesmix", 32'(asi_flush_aesmix), 32'd1);
            chk("flush_asi_valid", 32'(asi_valid), 32'd0);
            chk("flush_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
          end else begin
            chk("ready_owner", 32'({req1_ready, req0_ready}), mon_e.who ? 32'd2 : 32'd1);
            chk("result", mon_e.who ? req1_result : req0_result, mon_e.res);
            chk("nonowner_result", mon_e.who ? req0_result : req1_result, 32'd0);
            chk("ready_no_flush", 32'({asi_flush_aesmix, asi_flush_aessub}), 32'd0);
          end
        end
      end else begin
        chk("idle_results_zero", req0_result | req1_result, 32'd0);
      end
      chk("flush_data_zero", asi_flush_data, 32'd0);
    end
  end

  task automatic load0();
    if (pend0.size() > 0) begin
      req0_valid = 1'b1; req0_uop = pend0[0].uop; req0_rs1 = pend0[0].rs1;
      req0_rs2 = pend0[0].rs2; req0_shamt = pend0[0].shamt;
    end else begin
      req0_valid = 1'b0;
    end
  endtask

  task automatic load1();
    if (pend1.size() > 0) begin
      req1_valid = 1'b1; req1_uop = pend1[0].uop; req1_rs1 = pend1[0].rs1;
      req1_rs2 = pend1[0].rs2; req1_shamt = pend1[0].shamt;
    end else begin
      req1_valid = 1'b0;
    end
  endtask

  // Present queued ops; after a ready, swap in the next op once the completing edge has passed.
  task automatic run(int budget);
    int cyc;
    bit r0, r1;
    cyc = 0;
    load0();
    load1();
    while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && cyc < budget) begin
      @(negedge g_clk); #1;
      cyc++;
      r0 = req0_ready;
      r1 = req1_ready;
      if (r0 || r1) begin
        @(posedge g_clk); #1;
        if (r0) begin void'(pend0.pop_front()); load0(); end
        if (r1) begin void'(pend1.pop_front()); load1(); end
      end
    end
    chk("run_outstanding", 32'(sb.size() + pend0.size() + pend1.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge g_clk); #1;
    g_reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete(); pend0.delete(); pend1.delete();
    repeat (2) @(negedge g_clk);
    #1 g_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    op_t a, b, c, d;

    // Reset state
    repeat (3) @(negedge g_clk);
    chk("rst_asi_valid", 32'(asi_valid), 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_flush", 32'({asi_flush_aesmix, asi_flush_aessub}), 32'd0);
    chk("rst_asi_rs1", asi_rs1, 32'd0);
    chk("rst_asi_uop", 32'(asi_uop), 32'd0);
    #1 g_reset = 1'b0;

    // Single SHA2: ready in the first BUSY cycle, then back to IDLE
    @(negedge g_clk); #1;
    a = mk(U_SHA2, 32'h6a09e667, 32'hbb67ae84, 2'd0);
    pend0.push_back(a);
    exp_ready(1'b0, a);
    load0();
    @(negedge g_clk);
    chk("sha2_asi_valid_c1", 32'(asi_valid), 32'd1);
    chk("sha2_ready_c1", 32'(req0_ready), 32'd1);
    chk("sha2_asi_rs1", asi_rs1, 32'h6a09e667);
    chk("sha2_no_flush", 32'({asi_flush_aesmix, asi_flush_aessub}), 32'd0);
    @(posedge g_clk); #1;
    void'(pend0.pop_front());
    req0_valid = 1'b0;
    @(negedge g_clk);
    chk("sha2_idle_c2", 32'(asi_valid), 32'd0);

    // Contention: four back-to-back SHA3 ops from reset
    do_reset();
    a = mk(U_SHA3, 32'h11111111, 32'h22222220, 2'd1);
    b = mk(U_SHA3, 32'h33333333, 32'h44444444, 2'd2);
    c = mk(U_SHA3, 32'h55555555, 32'h66666664, 2'd3);
    d = mk(U_SHA3, 32'h77777777, 32'h88888888, 2'd0);
    pend0.push_back(a); pend0.push_back(b);
    pend1.push_back(c); pend1.push_back(d);
`ifdef FRV_ASI_ARB_RR_EN
    exp_ready(1'b0, a); exp_ready(1'b1, c); exp_ready(1'b0, b); exp_ready(1'b1, d);
`else
    exp_ready(1'b0, a); exp_ready(1'b0, b); exp_ready(1'b1, c); exp_ready(1'b1, d);
`endif
    run(100);

    // AES ownership change: flush on first req0 AES, on hand-over to req1, not on req1 repeat
    do_reset();
    a = mk(U_AES, 32'hdeadbeef, 32'h01020300, 2'd0);
    b = mk(U_AES, 32'hcafef00d, 32'h0a0b0c0c, 2'd1);
    c = mk(U_AES | 5'd3, 32'h0badc0de, 32'h10203040, 2'd2);
    pend0.push_back(a);
    pend1.push_back(b); pend1.push_back(c);
    exp_flush(); exp_ready(1'b0, a);
    exp_flush(); exp_ready(1'b1, b);
    exp_ready(1'b1, c);
    run(100);

    // Multi-cycle AES on req0 (3 stalled BUSY cycles) while req1 waits
    a = mk(U_AES, 32'h12345678, 32'h9abcdef3, 2'd0);
    b = mk(U_SHA2, 32'h0f0f0f0f, 32'hf0f0f0f0, 2'd1);
    pend0.push_back(a);
    pend1.push_back(b);
    exp_flush(); exp_ready(1'b0, a); exp_ready(1'b1, b);
    run(100);

    // Abort: req0 drops valid in its second BUSY cycle
    @(negedge g_clk); #1;
    a = mk(U_SHA2, 32'ha5a5a5a5, 32'h5a5a5a5b, 2'd0);
    pend0.push_back(a);
    load0();
    exp_flush();
    @(negedge g_clk);
    chk("abort_busy1_valid", 32'(asi_valid), 32'd1);
    chk("abort_busy1_ready", 32'(req0_ready), 32'd0);
    @(negedge g_clk); #1;
    req0_valid = 1'b0;
    void'(pend0.pop_front());
    @(negedge g_clk);
    chk("abort_idle_valid", 32'(asi_valid), 32'd0);
    chk("abort_no_ready", 32'(req0_ready), 32'd0);
    @(negedge g_clk);
    chk("abort_flush_once", 32'({asi_flush_aesmix, asi_flush_aessub}), 32'd0);
    // aes_owner was cleared, so req0's next AES op must flush again
    #1;
    a = mk(U_AES, 32'h00c0ffee, 32'h11110000, 2'd3);
    pend0.push_back(a);
    exp_flush(); exp_ready(1'b0, a);
    run(100);

    // Reset during BUSY
    @(negedge g_clk); #1;
    a = mk(U_SHA2, 32'hffff0000, 32'h00ffff03, 2'd2);
    pend1.push_back(a);
    load1();
    @(negedge g_clk);
    chk("mrst_busy", 32'(asi_valid), 32'd1);
    #1 g_reset = 1'b1;
    @(negedge g_clk);
    chk("mrst_asi_valid", 32'(asi_valid), 32'd0);
    chk("mrst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("mrst_result", req1_result, 32'd0);
    chk("mrst_asi_rs1", asi_rs1, 32'd0);
    chk("mrst_flush", 32'({asi_flush_aesmix, asi_flush_aessub}), 32'd0);
    #1;
    req1_valid = 1'b0;
    void'(pend1.pop_front());
    @(negedge g_clk); #1 g_reset = 1'b0;

    repeat (4) @(negedge g_clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
